// File: rtl/alu_srcb_stage.sv
// ----------------------------------------------------------------------------
// alu_srcb_stage
//
// Purpose: registered ALU operand-B source select. Chooses between the
// register-B value, an increment constant, an extended immediate, a shifted
// extended immediate and an upper-immediate form. The result is delivered
// through a 2-entry skid buffer so the ALU can stall without dropping an
// operand.
//
// Optional feature: define ALU_SRCB_STATS_EN to build the saturating
// illegal-select counter on stat_cnt. When undefined, stat_cnt is tied to 0.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   in_valid   in   upstream request valid
//   in_ready   out  stage can accept a request
//   sel        in   [2:0] source select (0 B, 1 INC, 2 ext, 3 ext<<SHIFT,
//                   4 imm16<<16, 5-7 illegal)
//   ext_zero   in   1 = zero-extend imm16, 0 = sign-extend
//   b_reg      in   [WIDTH-1:0] register-B value
//   imm16      in   [15:0] instruction immediate
//   out_valid  out  out_data/out_err valid
//   out_ready  in   downstream accepts the output
//   out_data   out  [WIDTH-1:0] selected operand B
//   out_err    out  output came from an illegal select
//   stat_cnt   out  [15:0] saturating illegal-select counter
//   dbg_state  out  [1:0] skid state (0 EMPTY, 1 ONE, 2 TWO)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds data stable while valid is high and ready is
// low; ready never depends combinationally on valid (in_ready is a register,
// gated only by reset).
// ----------------------------------------------------------------------------
module alu_srcb_stage #(
    parameter int WIDTH     = 32,
    parameter int INC_CONST = 4,
    parameter int SHIFT_AMT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic             ext_zero,
    input  logic [WIDTH-1:0] b_reg,
    input  logic [15:0]      imm16,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic [15:0]      stat_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              in_ready_q;
    logic [WIDTH-1:0]  out_data_q, skid_data_q;
    logic              out_err_q, skid_err_q;

    logic [WIDTH-1:0]  ext_imm;
    logic [WIDTH-1:0]  new_data;
    logic              new_err;
    logic              accept, xfer;
    logic              load_out_new, load_out_skid, load_skid;

    // Both handshake outputs are forced low during reset so nothing is
    // accepted or emitted in the reset cycle.
    assign in_ready  = in_ready_q & ~reset;
    assign out_valid = (state_q != ST_EMPTY) & ~reset;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign dbg_state = state_q;

    assign accept = in_valid & in_ready;
    assign xfer   = out_valid & out_ready;

    // Operand selection. Unknown sel values fall into the default arm and
    // are reported as illegal.
    always_comb begin
        ext_imm  = ext_zero ? {{(WIDTH-16){1'b0}}, imm16}
                            : {{(WIDTH-16){imm16[15]}}, imm16};
        new_data = '0;
        new_err  = 1'b0;
        case (sel)
            3'd0:    new_data = b_reg;
            3'd1:    new_data = WIDTH'(INC_CONST);
            3'd2:    new_data = ext_imm;
            3'd3:    new_data = ext_imm << SHIFT_AMT;
            3'd4:    new_data = WIDTH'({imm16, 16'h0000});
            default: new_err  = 1'b1;
        endcase
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
            if (load_out_new) begin
                out_data_q <= new_data;
                out_err_q  <= new_err;
            end else if (load_out_skid) begin
                out_data_q <= skid_data_q;
                out_err_q  <= skid_err_q;
            end
            if (load_skid) begin
                skid_data_q <= new_data;
                skid_err_q  <= new_err;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
                if (accept && !xfer)      state_d = ST_TWO;
                else if (!accept && xfer) state_d = ST_EMPTY;
            end
            ST_TWO:   if (xfer) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Register load enables. With the output register occupied, a new
    // request goes straight to it only when the current word leaves in the
    // same cycle; otherwise it parks in the skid entry.
    always_comb begin
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            ST_EMPTY: load_out_new = accept;
            ST_ONE: begin
                load_out_new = accept & xfer;
                load_skid    = accept & ~xfer;
            end
            ST_TWO:   load_out_skid = xfer;
            default: ;
        endcase
    end

`ifdef ALU_SRCB_STATS_EN
    logic [15:0] stat_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cnt_q <= '0;
        end else if (accept && new_err && (stat_cnt_q != 16'hFFFF)) begin
            stat_cnt_q <= stat_cnt_q + 16'd1;
        end
    end

    assign stat_cnt = stat_cnt_q;
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_srcb_stage.sv
module tb_alu_srcb_stage;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    sel;
    logic          ext_zero;
    logic [W-1:0]  b_reg;
    logic [15:0]   imm16;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_err;
    logic [15:0]   stat_cnt;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    alu_srcb_stage #(.WIDTH(W), .INC_CONST(4), .SHIFT_AMT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .ext_zero  (ext_zero),
        .b_reg     (b_reg),
        .imm16     (imm16),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .stat_cnt  (stat_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    // Entries are {err, data}; queue depth is the buffer occupancy.
    logic [W:0] exp_q[$];
    int unsigned stat_m;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference operand from the selection rules, using wide arithmetic.
    function automatic logic [W:0] ref_op(input int s, input bit ez,
                                          input logic [W-1:0] b, input logic [15:0] imm);
        longint ext;
        longint r;
        ext = ez ? longint'(imm) : longint'($signed(imm));
        case (s)
            0: return {1'b0, b};
            1: return {1'b0, 32'd4};
            2: begin r = ext;               return {1'b0, r[31:0]}; end
            3: begin r = ext * 4;           return {1'b0, r[31:0]}; end
            4: begin r = longint'(imm) * 65536; return {1'b0, r[31:0]}; end
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic logic [15:0] exp_stat();
`ifdef ALU_SRCB_STATS_EN
        return stat_m[15:0];
`else
        return 16'd0;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // One clock: compare visible outputs to the model, then advance.
    task automatic cycle();
        bit acc, xfr;
        logic [W:0] nv;
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
        check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) begin
            check("out_data", {32'd0, out_data}, {32'd0, exp_q[0][W-1:0]});
            check("out_err", {63'd0, out_err}, {63'd0, exp_q[0][W]});
        end
        check("stat_cnt", {48'd0, stat_cnt}, {48'd0, exp_stat()});
        acc = in_valid && (exp_q.size() < 2);
        xfr = out_ready && (exp_q.size() > 0);
        nv  = ref_op(int'(sel), ext_zero, b_reg, imm16);
        @(posedge clk); #1;
        if (xfr) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back(nv);
            if (nv[W] && stat_m != 32'hFFFF) stat_m++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        check("rst_out_err", {63'd0, out_err}, 64'd0);
        check("rst_stat", {48'd0, stat_cnt}, 64'd0);
        check("rst_in_ready_hold", {63'd0, in_ready}, 64'd0);
        reset = 1'b0;
        exp_q.delete();
        stat_m = 0;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic drive(input int s, input bit ez, input logic [W-1:0] b, input logic [15:0] imm);
        sel = 3'(s);
        ext_zero = ez;
        b_reg = b;
        imm16 = imm;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          s;
        bit          ez;
        logic [31:0] b;
        logic [15:0] imm;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1, 1'b0, 32'h0,        16'h0,    32'h00000004, 1'b0};
        vecs[1]  = '{2, 1'b0, 32'h0,        16'h8001, 32'hFFFF8001, 1'b0};
        vecs[2]  = '{2, 1'b1, 32'h0,        16'h8001, 32'h00008001, 1'b0};
        vecs[3]  = '{3, 1'b0, 32'h0,        16'h8001, 32'hFFFE0004, 1'b0};
        vecs[4]  = '{4, 1'b0, 32'h0,        16'h8001, 32'h80010000, 1'b0};
        vecs[5]  = '{4, 1'b1, 32'h0,        16'h8001, 32'h80010000, 1'b0};
        vecs[6]  = '{0, 1'b0, 32'hDEADBEEF, 16'h1234, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{3, 1'b1, 32'h0,        16'h8001, 32'h00020004, 1'b0};
        vecs[8]  = '{2, 1'b0, 32'h0,        16'h7FFF, 32'h00007FFF, 1'b0};
        vecs[9]  = '{6, 1'b0, 32'h1234,     16'h0,    32'h00000000, 1'b1};
        vecs[10] = '{5, 1'b1, 32'hFFFFFFFF, 16'hFFFF, 32'h00000000, 1'b1};
        vecs[11] = '{7, 1'b0, 32'h55AA55AA, 16'h8000, 32'h00000000, 1'b1};
        vecs[12] = '{3, 1'b0, 32'h0,        16'hFFFF, 32'hFFFFFFFC, 1'b0};
        vecs[13] = '{0, 1'b1, 32'h00000000, 16'hFFFF, 32'h00000000, 1'b0};
    end

    // ---------------- main sequence ----------------
    initial begin
        int illegal_seen;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        sel = '0; ext_zero = 1'b0; b_reg = '0; imm16 = '0;
        stat_m = 0;
        #2;
        do_reset();

        // Table vectors: one request at a time, checked against constants.
        out_ready = 1'b1;
        illegal_seen = 0;
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].s, vecs[i].ez, vecs[i].b, vecs[i].imm);
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            if (vecs[i].exp_err) illegal_seen++;
            check($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("vec%0d_data", i), {32'd0, out_data}, {32'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_err", i), {63'd0, out_err}, {63'd0, vecs[i].exp_err});
`ifdef ALU_SRCB_STATS_EN
            check($sformatf("vec%0d_stat", i), {48'd0, stat_cnt}, 64'(illegal_seen));
`else
            check($sformatf("vec%0d_stat", i), {48'd0, stat_cnt}, 64'd0);
`endif
            cycle();
        end

        // Stall: two entries fill the buffer, then drain in order.
        out_ready = 1'b0;
        drive(0, 1'b0, 32'hA, 16'h0); in_valid = 1'b1; cycle();
        drive(0, 1'b0, 32'hB, 16'h0); cycle();
        in_valid = 1'b0;
        check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        check("stall_data_a", {32'd0, out_data}, 64'hA);
        drive(0, 1'b0, 32'hC, 16'h0); in_valid = 1'b1;  // must not be taken
        cycle(); cycle();
        check("stall_hold_a", {32'd0, out_data}, 64'hA);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        check("drain_data_b", {32'd0, out_data}, 64'hB);
        check("drain_in_ready", {63'd0, in_ready}, 64'd1);
        cycle();
        check("drain_empty", {63'd0, out_valid}, 64'd0);

        // Reset while full: both entries discarded.
        out_ready = 1'b0;
        drive(0, 1'b0, 32'h111, 16'h0); in_valid = 1'b1; cycle();
        drive(0, 1'b0, 32'h222, 16'h0); cycle();
        in_valid = 1'b0;
        check("full_before_reset", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        do_reset();
        cycle(); cycle();
        check("no_stale_after_reset", {63'd0, out_valid}, 64'd0);

        // Back-to-back streaming with sel cycling 0..4.
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(i % 5, 1'($urandom_range(0, 1)), $urandom, 16'($urandom));
            cycle();
            check("stream_in_ready", {63'd0, in_ready}, 64'd1);
            check("stream_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        cycle();

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                in_valid  = 1'($urandom_range(0, 3) != 0);
                out_ready = 1'($urandom_range(0, 2) != 0);
                drive($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom, 16'($urandom));
                cycle();
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle(); cycle(); cycle();
        check("final_empty", {63'd0, out_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
